// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: bundle between the serial bit source and the frame receiver.
// The master side drives the serial bit S and observes the received word and
// status flags. The slave side is the receiver itself.
interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);

  logic             S;
  logic [WIDTH-1:0] WORD;
  logic             VALID;
  logic             LOCK;
  logic             PERR;

  modport master (output S, input WORD, input VALID, input LOCK, input PERR);
  modport slave  (input S, output WORD, output VALID, output LOCK, output PERR);

endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: takes the serial bit stream from the last stage of the
// 2-bit shift register. It hunts for a SYNC_PAT sync pattern, then assembles
// WIDTH-bit words MSB-first and strobes VALID for one cycle per word. It
// re-checks the sync pattern after every word and drops LOCK when that check fails.
// Optional feature macro: PARITY_EN adds one even-parity bit per frame and
// drives PERR. When PARITY_EN is undefined there is no parity bit and PERR is 0.
module serial_frame_rx #(
  parameter int                  WIDTH    = 8,
  parameter int                  SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1011
) (
  input logic              C,
  input logic              R,
  serial_frame_rx_if.slave bus
);

  // The counters only ever reach the larger of WIDTH and SYNC_LEN, so they cannot wrap.
  localparam int MAXCNT = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
  localparam int CW     = $clog2(MAXCNT + 1);

  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CHK  = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] FILL_FULL = CW'(SYNC_LEN);

`ifdef PARITY_EN
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, PAR = 2'd2, CHK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, CHK = 2'd3} state_t;
`endif

  state_t              state_q, state_d;
  logic [SYNC_LEN-1:0] window_q, window_d;
  logic [CW-1:0]       fill_q, fill_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic                valid_q, valid_d;
  logic                lock_q, lock_d;
  logic                syncHit;
`ifdef PARITY_EN
  logic                perr_q, perr_d;
`endif

  // Next-state logic. The sync window and the fill counter advance in every
  // state, so a sync pattern that follows a failed check can lock on the very next edge.
  always_comb begin
    state_d    = state_q;
    window_d   = {window_q[SYNC_LEN-2:0], bus.S};
    fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    cnt_d      = cnt_q;
    shiftReg_d = shiftReg_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    lock_d     = lock_q;
`ifdef PARITY_EN
    perr_d     = perr_q;
`endif
    syncHit    = (window_d == SYNC_PAT);

    case (state_q)
      HUNT: begin
        if ((fill_d == FILL_FULL) && syncHit) begin
          lock_d  = 1'b1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        shiftReg_d = {shiftReg_q[WIDTH-2:0], bus.S};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_DATA) begin
          cnt_d   = '0;
`ifdef PARITY_EN
          state_d = PAR;
`else
          word_d  = shiftReg_d;
          valid_d = 1'b1;
          state_d = CHK;
`endif
        end
      end
`ifdef PARITY_EN
      PAR: begin
        word_d  = shiftReg_q;
        valid_d = 1'b1;
        perr_d  = (^shiftReg_q) != bus.S;
        cnt_d   = '0;
        state_d = CHK;
      end
`endif
      CHK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CHK) begin
          cnt_d = '0;
          if (syncHit) begin
            state_d = DATA;
          end else begin
            lock_d  = 1'b0;
            state_d = HUNT;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // State and registered outputs. Reset clears everything immediately, which
  // also discards any partially assembled word.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q    <= HUNT;
      window_q   <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      shiftReg_q <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
`ifdef PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      shiftReg_q <= shiftReg_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
`ifdef PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign bus.WORD  = word_q;
  assign bus.VALID = valid_q;
  assign bus.LOCK  = lock_q;
`ifdef PARITY_EN
  assign bus.PERR  = perr_q;
`else
  assign bus.PERR  = 1'b0;
`endif

endmodule
